// File: rtl/ula_seq_multibyte_if.sv
// Request/result bundle for the multibyte ALU sequencer.
// master = requester, slave = sequencer.
interface ula_seq_multibyte_if #(
  parameter int N_BYTES = 2
);
  localparam int W = 8 * N_BYTES;

  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [3:0]   op_s;
  logic         op_m;
  logic         op_c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         res_c_out;
  logic         res_overflow;
  logic         res_a_eq_b;

  modport master (
    output start, op_a, op_b,
    output op_s, op_m, op_c_in,
    input  busy, done, result,
    input  res_c_out, res_overflow,
    input  res_a_eq_b
  );

  modport slave (
    input  start, op_a, op_b,
    input  op_s, op_m, op_c_in,
    output busy, done, result,
    output res_c_out, res_overflow,
    output res_a_eq_b
  );
endinterface

// File: rtl/ula_seq_multibyte.sv
// Drives one shared ula_8_bits a byte per clock, LSB first,
// chaining carry and assembling a wide result.
module ula_seq_multibyte #(
  parameter int N_BYTES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ula_seq_multibyte_if.slave   bus,
  output logic [7:0]           ula_a,
  output logic [7:0]           ula_b,
  output logic [3:0]           ula_s,
  output logic                 ula_m,
  output logic                 ula_c_in,
  input  logic [7:0]           ula_f,
  input  logic                 ula_a_eq_b,
  input  logic                 ula_c_out,
  input  logic                 ula_overflow
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam int IW =
    (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IW-1:0] LAST =
    IW'(N_BYTES - 1);

  logic [0:0]               state;
  logic [IW-1:0]            idx;
  logic [N_BYTES-1:0][7:0]  a_lat;
  logic [N_BYTES-1:0][7:0]  b_lat;
  logic [N_BYTES-1:0][7:0]  stage;
  logic [N_BYTES-1:0][7:0]  stage_nx;
  logic [N_BYTES-1:0][7:0]  res_q;
  logic [3:0]               s_lat;
  logic                     m_lat;
  logic                     carry;
  logic                     eq_acc;
  logic                     busy_q;
  logic                     done_q;
  logic                     c_q;
  logic                     ov_q;
  logic                     eq_q;
  logic                     run;

  assign run = (state == RUN);

  // ALU sees zeros while idle so it never
  // toggles on stale operands.
  always_comb begin
    ula_a    = '0;
    ula_b    = '0;
    ula_s    = '0;
    ula_m    = 1'b0;
    ula_c_in = 1'b0;
    if (run) begin
      ula_a    = a_lat[idx];
      ula_b    = b_lat[idx];
      ula_s    = s_lat;
      ula_m    = m_lat;
      ula_c_in = carry;
    end
  end

  always_comb begin
    stage_nx      = stage;
    stage_nx[idx] = ula_f;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      a_lat  <= '0;
      b_lat  <= '0;
      stage  <= '0;
      s_lat  <= '0;
      m_lat  <= 1'b0;
      carry  <= 1'b0;
      eq_acc <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      res_q  <= '0;
      c_q    <= 1'b0;
      ov_q   <= 1'b0;
      eq_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_lat  <= bus.op_a;
            b_lat  <= bus.op_b;
            s_lat  <= bus.op_s;
            m_lat  <= bus.op_m;
            carry  <= bus.op_c_in;
            eq_acc <= 1'b1;
            idx    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          stage  <= stage_nx;
          carry  <= ula_c_out;
          eq_acc <= eq_acc & ula_a_eq_b;
          idx    <= idx + 1'b1;
          if (idx == LAST) begin
            res_q  <= stage_nx;
            c_q    <= ula_c_out;
            ov_q   <= ula_overflow;
            eq_q   <= eq_acc & ula_a_eq_b;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            idx    <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.result       = res_q;
  assign bus.res_c_out    = c_q;
  assign bus.res_overflow = ov_q;
  assign bus.res_a_eq_b   = eq_q;

endmodule

// File: tb/tb_ula_seq_multibyte.sv
// Directed bench for ula_seq_multibyte with a small
// behavioural stand-in for ula_8_bits.
module tb_ula_seq_multibyte;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ula_seq_multibyte_if #(.N_BYTES(2)) bus ();

  logic [7:0] ula_a;
  logic [7:0] ula_b;
  logic [3:0] ula_s;
  logic       ula_m;
  logic       ula_c_in;
  logic [7:0] ula_f;
  logic       ula_a_eq_b;
  logic       ula_c_out;
  logic       ula_overflow;

  ula_seq_multibyte #(.N_BYTES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .ula_a        (ula_a),
    .ula_b        (ula_b),
    .ula_s        (ula_s),
    .ula_m        (ula_m),
    .ula_c_in     (ula_c_in),
    .ula_f        (ula_f),
    .ula_a_eq_b   (ula_a_eq_b),
    .ula_c_out    (ula_c_out),
    .ula_overflow (ula_overflow)
  );

  // ALU stand-in: s=0101 add, s=1000 subtract
  // (c_in/c_out act as borrow), logic mode xor.
  logic [8:0] t9;
  always_comb begin
    t9           = '0;
    ula_f        = '0;
    ula_c_out    = 1'b0;
    ula_overflow = 1'b0;
    ula_a_eq_b   = (ula_a == ula_b);
    if (!ula_m && ula_s == 4'b0101) begin
      t9 = {1'b0, ula_a} + {1'b0, ula_b}
         + {8'd0, ula_c_in};
      ula_f        = t9[7:0];
      ula_c_out    = t9[8];
      ula_overflow = (ula_a[7] == ula_b[7]) &&
                     (t9[7] != ula_a[7]);
    end else if (!ula_m && ula_s == 4'b1000) begin
      t9 = {1'b0, ula_a} - {1'b0, ula_b}
         - {8'd0, ula_c_in};
      ula_f        = t9[7:0];
      ula_c_out    = t9[8];
      ula_overflow = (ula_a[7] != ula_b[7]) &&
                     (t9[7] != ula_a[7]);
    end else if (ula_m) begin
      ula_f = ula_a ^ ula_b;
    end
  end

  int checks = 0;
  int errors = 0;
  int lat;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [3:0]  s,
    input logic        m,
    input logic        c
  );
    bus.op_a    = a;
    bus.op_b    = b;
    bus.op_s    = s;
    bus.op_m    = m;
    bus.op_c_in = c;
    bus.start   = 1'b1;
    step();
    bus.start   = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 12) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.op_a = '0; bus.op_b = '0;
    bus.op_s = '0; bus.op_m = 1'b0;
    bus.op_c_in = 1'b0;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_busy_done got %b want 00",
               {bus.busy, bus.done});
    end
    checks++;
    if ({bus.result, bus.res_c_out, bus.res_overflow,
         bus.res_a_eq_b} !== 19'h0) begin
      errors++;
      $display("FAIL reset_result got %h c%b v%b e%b want 0",
               bus.result, bus.res_c_out,
               bus.res_overflow, bus.res_a_eq_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if ({ula_a, ula_b, ula_s, ula_m, ula_c_in} !== 22'h0) begin
      errors++;
      $display("FAIL idle_ula_drive got a%h b%h s%h want 0",
               ula_a, ula_b, ula_s);
    end
  endtask

  task automatic test_add();
    start_op(16'h00FF, 16'h0001, 4'b0101, 1'b0, 1'b0);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL add_busy got %b want 1", bus.busy);
    end
    wait_done(lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL add_latency got %0d want 2", lat);
    end
    checks++;
    if ({bus.result, bus.res_c_out, bus.res_overflow}
        !== {16'h0100, 2'b00}) begin
      errors++;
      $display("FAIL add_carry_cross got %h c%b v%b want 0100 c0 v0",
               bus.result, bus.res_c_out, bus.res_overflow);
    end
    step();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width got %b want 0", bus.done);
    end
    start_op(16'h7FFF, 16'h0001, 4'b0101, 1'b0, 1'b0);
    wait_done(lat);
    checks++;
    if ({bus.result, bus.res_c_out, bus.res_overflow}
        !== {16'h8000, 2'b01} || lat !== 2) begin
      errors++;
      $display("FAIL add_ovf got %h c%b v%b lat%0d want 8000 c0 v1 lat2",
               bus.result, bus.res_c_out, bus.res_overflow, lat);
    end
    start_op(16'hFFFF, 16'h0001, 4'b0101, 1'b0, 1'b0);
    wait_done(lat);
    checks++;
    if ({bus.result, bus.res_c_out, bus.res_overflow}
        !== {16'h0000, 2'b10}) begin
      errors++;
      $display("FAIL add_wrap got %h c%b v%b want 0000 c1 v0",
               bus.result, bus.res_c_out, bus.res_overflow);
    end
  endtask

  task automatic test_sub();
    start_op(16'h0100, 16'h0001, 4'b1000, 1'b0, 1'b0);
    wait_done(lat);
    checks++;
    if (bus.result !== 16'h00FF || lat !== 2) begin
      errors++;
      $display("FAIL sub_borrow got %h lat%0d want 00ff lat2",
               bus.result, lat);
    end
    start_op(16'h8000, 16'h0001, 4'b1000, 1'b0, 1'b0);
    wait_done(lat);
    checks++;
    if ({bus.result, bus.res_overflow} !== {16'h7FFF, 1'b1}) begin
      errors++;
      $display("FAIL sub_ovf got %h v%b want 7fff v1",
               bus.result, bus.res_overflow);
    end
  endtask

  task automatic test_logic();
    start_op(16'h0F0F, 16'h00FF, 4'b0110, 1'b1, 1'b1);
    wait_done(lat);
    checks++;
    if ({bus.result, bus.res_c_out} !== {16'h0FF0, 1'b0}) begin
      errors++;
      $display("FAIL logic_xor got %h c%b want 0ff0 c0",
               bus.result, bus.res_c_out);
    end
  endtask

  task automatic test_equal();
    start_op(16'h55AA, 16'h55AA, 4'b1000, 1'b0, 1'b0);
    wait_done(lat);
    checks++;
    if (bus.res_a_eq_b !== 1'b1) begin
      errors++;
      $display("FAIL eq_same got %b want 1", bus.res_a_eq_b);
    end
    start_op(16'h55AA, 16'hD5AA, 4'b1000, 1'b0, 1'b0);
    wait_done(lat);
    checks++;
    if (bus.res_a_eq_b !== 1'b0) begin
      errors++;
      $display("FAIL eq_hi_diff got %b want 0", bus.res_a_eq_b);
    end
    start_op(16'h55AA, 16'h55AB, 4'b1000, 1'b0, 1'b0);
    wait_done(lat);
    checks++;
    if (bus.res_a_eq_b !== 1'b0) begin
      errors++;
      $display("FAIL eq_lo_diff got %b want 0", bus.res_a_eq_b);
    end
  endtask

  task automatic test_busy_ignore();
    start_op(16'h00FF, 16'h0001, 4'b0101, 1'b0, 1'b0);
    bus.op_a  = 16'h1111;
    bus.op_b  = 16'h2222;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done(lat);
    checks++;
    if (bus.result !== 16'h0100 || lat !== 1) begin
      errors++;
      $display("FAIL busy_ignore got %h lat%0d want 0100 lat1",
               bus.result, lat);
    end
    step();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL start_not_queued busy got %b want 0",
               bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    start_op(16'h0001, 16'h0002, 4'b0101, 1'b0, 1'b0);
    wait_done(lat);
    start_op(16'h1000, 16'h0234, 4'b0101, 1'b0, 1'b0);
    checks++;
    if (bus.busy !== 1'b1 || bus.result !== 16'h0003) begin
      errors++;
      $display("FAIL b2b_accept busy%b res %h want busy1 0003",
               bus.busy, bus.result);
    end
    step();
    checks++;
    if (bus.result !== 16'h0003) begin
      errors++;
      $display("FAIL b2b_hold got %h want 0003", bus.result);
    end
    wait_done(lat);
    checks++;
    if (bus.result !== 16'h1234 || lat !== 1) begin
      errors++;
      $display("FAIL b2b_second got %h lat%0d want 1234 lat1",
               bus.result, lat);
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    start_op(16'h00FF, 16'h0001, 4'b0101, 1'b0, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.result} !== 18'h0) begin
      errors++;
      $display("FAIL abort_clear got b%b d%b r%h want 0",
               bus.busy, bus.done, bus.result);
    end
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.done) seen++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.done) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_no_done got %0d pulses want 0", seen);
    end
    start_op(16'h1234, 16'h1111, 4'b0101, 1'b0, 1'b0);
    wait_done(lat);
    checks++;
    if (bus.result !== 16'h2345 || lat !== 2) begin
      errors++;
      $display("FAIL post_reset_add got %h lat%0d want 2345 lat2",
               bus.result, lat);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_equal();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ula_seq_multibyte.md
Name: ula_seq_multibyte

Overview:
- Sequencing front/back stage for the existing combinational ula_8_bits.
- Accepts a wide operation (N_BYTES × 8 bits) through a start/done handshake and drives the ALU one byte per clock, LSB byte first.
- Chains the ALU carry between passes and captures the ALU outputs each pass.
- Presents the assembled wide result, carry, signed overflow and equality flag.
- Owns the ula_8_bits instance's input ports and consumes its outputs, so the ALU is reused serially instead of being replicated.

Parameters:
- N_BYTES, 2, number of 8-bit passes per operation; legal range 1..8; operand width W = 8*N_BYTES.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- op_a  input  W  operand A.
- op_b  input  W  operand B.
- op_s  input  4  ALU function select, passed to the ALU s input.
- op_m  input  1  ALU mode (0 arithmetic, 1 logic), passed to the ALU m input.
- op_c_in  input  1  carry-in for the first (LSB) byte pass.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; result fields are valid from this cycle onward.
- result  output  W  assembled ALU output f.
- res_c_out  output  1  c_out of the last (MSB) pass.
- res_overflow  output  1  overflow of the last (MSB) pass.
- res_a_eq_b  output  1  AND of a_eq_b over all passes.
- ula_a  output  8  to ALU a.
- ula_b  output  8  to ALU b.
- ula_s  output  4  to ALU s.
- ula_m  output  1  to ALU m.
- ula_c_in  output  1  to ALU c_in.
- ula_f  input  8  from ALU f.
- ula_a_eq_b  input  1  from ALU a_eq_b.
- ula_c_out  input  1  from ALU c_out.
- ula_overflow  input  1  from ALU overflow.

Behaviour:
- Reset (async, rst_n=0): state=IDLE.
  - busy=0, done=0, result=0, res_c_out=0, res_overflow=0, res_a_eq_b=0.
  - All internal staging registers, byte index and carry register are cleared.
  - Reset asserted mid-operation aborts it; no done is produced.
- States: IDLE and RUN.
- IDLE:
  - ula_* outputs are all 0.
  - start=1 at a rising edge latches op_a, op_b, op_s, op_m and op_c_in; sets idx=0, carry=op_c_in, eq_acc=1; moves to RUN; busy=1 next cycle.
- RUN:
  - Combinational drive: ula_a=a_lat[8*idx+:8], ula_b=b_lat[8*idx+:8], ula_s=s_lat, ula_m=m_lat, ula_c_in=carry.
  - Each edge captures stage[8*idx+:8]=ula_f, carry=ula_c_out, eq_acc=eq_acc&ula_a_eq_b, then idx increments.
  - When idx==N_BYTES-1:
    - commit result=stage (with the current ula_f merged in), res_c_out=ula_c_out, res_overflow=ula_overflow, res_a_eq_b=eq_acc&ula_a_eq_b;
    - done=1 for the next cycle; busy=0; return to IDLE.
  - The ALU is combinational and is sampled in the same cycle its operands are driven.
- Latency: start accepted at edge T → done high during the cycle after edge T+N_BYTES (N_BYTES+1 cycles).
- Throughput: one operation per N_BYTES+1 cycles. A start seen in the done cycle is accepted, giving back-to-back operation.
- start while busy=1 is ignored; it is not queued.
- Operand inputs may change freely after acceptance; the latched copies are used.
- Result outputs hold their value until the next commit. They never show partial bytes mid-operation.
- Carry chaining matches the cascade of 4-bit slices inside ula_8_bits, so a W-bit operation equals a single W-bit ALU of the same family.
- Carry is chained in logic mode too; it is harmless because the ALU ignores it there.
- Overflow reflects only the MSB pass, which gives the two's-complement overflow of the full word.
- N_BYTES=1: a single pass, latency 2.

Test Plan:
- Reset, then m=0, s=0101, c_in=0, A=0x00FF, B=0x0001, start pulse → done exactly 3 cycles later; result=0x0100, res_c_out=0, res_overflow=0. This shows the carry crossing bytes.
- Add with A=0x7FFF, B=0x0001 → result=0x8000, res_overflow=1, res_c_out=0. Add with A=0xFFFF, B=0x0001 → result=0x0000, res_c_out=1, res_overflow=0.
- Subtract m=0, s=1000, c_in=0, A=0x0100, B=0x0001 → result=0x00FF (borrow propagates into the high byte). Also A=0x8000, B=0x0001 → result=0x7FFF, res_overflow=1.
- Equality with A=B=0x55AA → res_a_eq_b=1. A=0x55AA, B=0xD5AA → 0 (high-byte mismatch). A=0x55AA, B=0x55AB → 0 (low-byte mismatch).
- Pulse start again while busy with different operands → ignored; the first operation's result is unchanged. Start asserted in the done cycle → second operation accepted, done 3 cycles later.
- Assert rst_n=0 one cycle into RUN → all outputs 0 immediately, no done pulse. After release, a fresh 0x1234+0x1111 → 0x2345.
